// File: rtl/vctr_seq_pkg.sv
// ---------------------------------------------------------------------------
// vctr_seq_pkg
// Shared definitions for the vector fetch sequencer: the sequencer state
// encoding, the default fetch address stride and the data/count widths.
// No ports; imported by vctr_fetch_sequencer.
// ---------------------------------------------------------------------------
package vctr_seq_pkg;

  // Default byte stride between consecutive fetch addresses
  localparam int unsigned ADDR_INCR_DEF = 4;

  // Default width of FIFO word counts and their thresholds
  localparam int unsigned CNT_W_DEF = 16;

  // Fixed widths of the fetch address path and the consecutive-run counter
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned CONSEC_W = 8;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/vctr_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// vctr_fetch_sequencer
// Pops base addresses from a first-word-fall-through address FIFO and turns
// each one into a run of 1 + consec_count fetch requests, stepping by
// ADDR_INCR bytes. Requests are throttled by the vector FIFO high-water mark.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   run_program, end_program,    driver control: start, finish after the
//   abort_program, program_error current run, immediate abort / error
//   freeze_addr_fifo             inhibit address FIFO pops
//   send_consec_addr,            enable consecutive-address expansion and
//   consec_count                 number of extra fetches per popped address
//   addr_fifo_dout/_empty        address FIFO head word and empty flag
//   addr_fifo_rd                 one-cycle address FIFO pop strobe
//   words_in_addr_fifo,          start condition (count >= threshold)
//   addr_fifo_threshold
//   words_in_vctr_fifo,          fetches only while count < threshold
//   vector_fifo_threshold
//   fetch_valid/addr/ready       fetch request handshake
//   seq_busy, seq_done           status (POP/ISSUE, DONE)
//   fetch_issued                 accepted fetches since the run started
//   stall_cycles                 only with VCTR_SEQ_STALL_CNT_EN defined:
//                                ISSUE cycles with fetch_valid low, saturating
// ---------------------------------------------------------------------------
module vctr_fetch_sequencer
  import vctr_seq_pkg::*;
#(
  parameter int unsigned ADDR_INCR = ADDR_INCR_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_program,
  input  logic                end_program,
  input  logic                abort_program,
  input  logic                freeze_addr_fifo,
  input  logic                send_consec_addr,
  input  logic [CONSEC_W-1:0] consec_count,
  input  logic                program_error,
  input  logic [ADDR_W-1:0]   addr_fifo_dout,
  input  logic                addr_fifo_empty,
  input  logic [CNT_W-1:0]    words_in_addr_fifo,
  input  logic [CNT_W-1:0]    addr_fifo_threshold,
  input  logic [CNT_W-1:0]    words_in_vctr_fifo,
  input  logic [CNT_W-1:0]    vector_fifo_threshold,
  output logic                addr_fifo_rd,
  output logic                fetch_valid,
  output logic [ADDR_W-1:0]   fetch_addr,
  input  logic                fetch_ready,
  output logic                seq_busy,
  output logic                seq_done,
  output logic [31:0]         fetch_issued
`ifdef VCTR_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  seq_state_t          state_q;
  seq_state_t          state_d;
  logic [CONSEC_W-1:0] remaining_q;
  logic                end_pending_q;

  logic kill;
  logic start;
  logic can_pop;
  logic vctr_room;
  logic handshake;
  logic load;
  logic clear_cnt;

  assign kill      = abort_program | program_error;
  assign start     = run_program && (words_in_addr_fifo >= addr_fifo_threshold);
  assign can_pop   = !addr_fifo_empty && !freeze_addr_fifo;
  assign vctr_room = words_in_vctr_fifo < vector_fifo_threshold;
  assign handshake = fetch_valid && fetch_ready;

  assign seq_busy = (state_q == ST_POP) || (state_q == ST_ISSUE);
  assign seq_done = (state_q == ST_DONE);

  // Next-state and strobe decode. Abort/error is applied last so it overrides
  // every other transition and also masks the pop strobe and fetch_valid in
  // the abort cycle, so no request can be accepted while being torn down.
  // The pop strobe is only produced in POP and the state always leaves POP
  // on a pop, so pops are at least two cycles apart.
  always_comb begin
    state_d      = state_q;
    addr_fifo_rd = 1'b0;
    fetch_valid  = 1'b0;
    load         = 1'b0;
    clear_cnt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_POP;
          clear_cnt = 1'b1;
        end
      end
      ST_POP: begin
        if (end_program) begin
          state_d = ST_DONE;
        end else if (can_pop) begin
          addr_fifo_rd = 1'b1;
          load         = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fetch_valid = vctr_room;
        if (vctr_room && fetch_ready && (remaining_q == '0)) begin
          state_d = (end_program || end_pending_q) ? ST_DONE : ST_POP;
        end
      end
      ST_DONE: begin
        if (!run_program) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d      = ST_IDLE;
      addr_fifo_rd = 1'b0;
      fetch_valid  = 1'b0;
      load         = 1'b0;
      clear_cnt    = 1'b0;
    end
  end

  // State, address run and counters. An end request seen mid-run is latched
  // so a one-cycle end_program pulse still ends the program once the current
  // address run has drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fetch_addr    <= '0;
      remaining_q   <= '0;
      fetch_issued  <= '0;
      end_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (clear_cnt) begin
        fetch_issued <= '0;
      end else if (handshake) begin
        fetch_issued <= fetch_issued + 32'd1;
      end

      if (load) begin
        fetch_addr  <= addr_fifo_dout;
        remaining_q <= send_consec_addr ? consec_count : '0;
      end else if (handshake && (remaining_q != '0)) begin
        fetch_addr  <= fetch_addr + ADDR_W'(ADDR_INCR);
        remaining_q <= remaining_q - 1'b1;
      end

      if ((state_q == ST_ISSUE) && !kill) begin
        end_pending_q <= end_pending_q | end_program;
      end else begin
        end_pending_q <= 1'b0;
      end
    end
  end

`ifdef VCTR_SEQ_STALL_CNT_EN
  // Cycles spent in ISSUE without a valid request (vector FIFO full or abort)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (clear_cnt) begin
      stall_cycles <= '0;
    end else if ((state_q == ST_ISSUE) && !fetch_valid && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vctr_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vctr_fetch_sequencer
// Directed bench for vctr_fetch_sequencer. Stimulus pushes the expected fetch
// addresses into a queue; a negedge monitor pops and compares on every
// accepted fetch and polices address FIFO pops.
// ---------------------------------------------------------------------------
module tb_vctr_fetch_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             run_program, end_program, abort_program;
  logic             freeze_addr_fifo, send_consec_addr, program_error;
  logic [7:0]       consec_count;
  logic [31:0]      addr_fifo_dout;
  logic             addr_fifo_empty;
  logic [CNT_W-1:0] words_in_addr_fifo, addr_fifo_threshold;
  logic [CNT_W-1:0] words_in_vctr_fifo, vector_fifo_threshold;
  logic             addr_fifo_rd, fetch_valid, fetch_ready;
  logic [31:0]      fetch_addr;
  logic             seq_busy, seq_done;
  logic [31:0]      fetch_issued;
`ifdef VCTR_SEQ_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          pop_cnt = 0;
  bit          pop_pending = 1'b0;
  logic        prev_rd = 1'b0;

  vctr_fetch_sequencer #(.ADDR_INCR(4), .CNT_W(CNT_W)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .run_program           (run_program),
    .end_program           (end_program),
    .abort_program         (abort_program),
    .freeze_addr_fifo      (freeze_addr_fifo),
    .send_consec_addr      (send_consec_addr),
    .consec_count          (consec_count),
    .program_error         (program_error),
    .addr_fifo_dout        (addr_fifo_dout),
    .addr_fifo_empty       (addr_fifo_empty),
    .words_in_addr_fifo    (words_in_addr_fifo),
    .addr_fifo_threshold   (addr_fifo_threshold),
    .words_in_vctr_fifo    (words_in_vctr_fifo),
    .vector_fifo_threshold (vector_fifo_threshold),
    .addr_fifo_rd          (addr_fifo_rd),
    .fetch_valid           (fetch_valid),
    .fetch_addr            (fetch_addr),
    .fetch_ready           (fetch_ready),
    .seq_busy              (seq_busy),
    .seq_done              (seq_done),
    .fetch_issued          (fetch_issued)
`ifdef VCTR_SEQ_STALL_CNT_EN
    ,
    .stall_cycles          (stall_cycles)
`endif
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point; every check steps the same counters
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n cycles, ending 1 ns after the rising edge
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Refresh the FWFT view of the address FIFO model
  task automatic fifoRefresh();
    addr_fifo_empty = (fifo_q.size() == 0);
    addr_fifo_dout  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
  endtask

  task automatic fifoPush(input logic [31:0] w);
    fifo_q.push_back(w);
    fifoRefresh();
  endtask

  // Wait (bounded) until every expected fetch has been seen
  task automatic waitDrain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) applyStimulus(1);
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: police pops and score every accepted fetch against the queue
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      prev_rd = 1'b0;
    end else begin
      if (addr_fifo_rd) begin
        checkOutput("pop_nonempty", {31'b0, addr_fifo_empty}, 32'd0);
        checkOutput("pop_spacing", {31'b0, prev_rd}, 32'd0);
        pop_cnt++;
        pop_pending = 1'b1;
      end
      prev_rd = addr_fifo_rd;
      if (fetch_valid && fetch_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("[TB] FAIL unexpected_fetch: got addr 0x%0h, expected no fetch", fetch_addr);
        end else begin
          e = exp_q.pop_front();
          checkOutput("fetch_addr", fetch_addr, e);
        end
      end
    end
  end

  // Address FIFO model retires the popped word just after the edge
  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      pop_pending = 1'b0;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifoRefresh();
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    run_program = 0; end_program = 0; abort_program = 0; program_error = 0;
    freeze_addr_fifo = 0; send_consec_addr = 0; consec_count = 8'd0;
    fetch_ready = 0;
    words_in_addr_fifo = '0; addr_fifo_threshold = '0;
    words_in_vctr_fifo = '0; vector_fifo_threshold = '0;
    fifoRefresh();

    // Reset state
    #3;
    checkOutput("rst_valid", {31'b0, fetch_valid}, 32'd0);
    checkOutput("rst_rd", {31'b0, addr_fifo_rd}, 32'd0);
    checkOutput("rst_busy", {31'b0, seq_busy}, 32'd0);
    checkOutput("rst_done", {31'b0, seq_done}, 32'd0);
    checkOutput("rst_addr", fetch_addr, 32'd0);
    checkOutput("rst_issued", fetch_issued, 32'd0);
    applyStimulus(1);
    reset = 1'b0;

    // Start threshold: 9 of 10 words stays IDLE, the 10th starts the run
    addr_fifo_threshold = 16'd10; words_in_addr_fifo = 16'd9;
    vector_fifo_threshold = 16'd7500; words_in_vctr_fifo = 16'd0;
    run_program = 1'b1;
    applyStimulus(3);
    checkOutput("thr_idle", {31'b0, seq_busy}, 32'd0);
    words_in_addr_fifo = 16'd10;
    applyStimulus(1);
    checkOutput("thr_pop", {31'b0, seq_busy}, 32'd1);
    applyStimulus(1);
    checkOutput("empty_wait_busy", {31'b0, seq_busy}, 32'd1);
    checkOutput("empty_wait_rd", {31'b0, addr_fifo_rd}, 32'd0);
    checkOutput("empty_wait_pops", 32'(pop_cnt), 32'd0);

    // Consecutive run: 0x1000 + 3 extra fetches, then back to POP
    send_consec_addr = 1'b1; consec_count = 8'd3; fetch_ready = 1'b1;
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1004);
    exp_q.push_back(32'h1008); exp_q.push_back(32'h100C);
    fifoPush(32'h1000);
    waitDrain("consec_drain");
    checkOutput("consec_issued", fetch_issued, 32'd4);
    checkOutput("consec_pops", 32'(pop_cnt), 32'd1);
    checkOutput("consec_busy", {31'b0, seq_busy}, 32'd1);
    checkOutput("consec_last_addr", fetch_addr, 32'h100C);

    // Vector FIFO at threshold holds the request, one below releases it
    words_in_vctr_fifo = 16'd7500; consec_count = 8'd1;
    exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
    fifoPush(32'h3000);
    applyStimulus(3);
    checkOutput("hwm_valid", {31'b0, fetch_valid}, 32'd0);
    checkOutput("hwm_addr", fetch_addr, 32'h3000);
    applyStimulus(1);
    checkOutput("hwm_addr_hold", fetch_addr, 32'h3000);
    words_in_vctr_fifo = 16'd7499;
    applyStimulus(1);
    checkOutput("hwm_release", {31'b0, fetch_valid}, 32'd1);
    waitDrain("hwm_drain");
    checkOutput("hwm_issued", fetch_issued, 32'd6);
    checkOutput("hwm_pops", 32'(pop_cnt), 32'd2);

    // Abort while a request is stalled on fetch_ready
    fetch_ready = 1'b0; send_consec_addr = 1'b0; consec_count = 8'd0;
    fifoPush(32'h4000); fifoPush(32'h5000);
    applyStimulus(2);
    checkOutput("abort_pre_valid", {31'b0, fetch_valid}, 32'd1);
    checkOutput("abort_pre_addr", fetch_addr, 32'h4000);
    abort_program = 1'b1; run_program = 1'b0;
    applyStimulus(1);
    abort_program = 1'b0;
    checkOutput("abort_valid", {31'b0, fetch_valid}, 32'd0);
    checkOutput("abort_busy", {31'b0, seq_busy}, 32'd0);
    applyStimulus(3);
    checkOutput("abort_pops", 32'(pop_cnt), 32'd3);
    checkOutput("abort_fifo_left", 32'(fifo_q.size()), 32'd1);

    // End request during a 3-deep run finishes the run, then DONE
    send_consec_addr = 1'b1; consec_count = 8'd2; run_program = 1'b1;
    exp_q.push_back(32'h5000); exp_q.push_back(32'h5004); exp_q.push_back(32'h5008);
    applyStimulus(3);
    checkOutput("end_issued_clr", fetch_issued, 32'd0);
    end_program = 1'b1; fetch_ready = 1'b1;
    waitDrain("end_drain");
    checkOutput("end_done", {31'b0, seq_done}, 32'd1);
    checkOutput("end_busy", {31'b0, seq_busy}, 32'd0);
    checkOutput("end_issued", fetch_issued, 32'd3);
    checkOutput("end_pops", 32'(pop_cnt), 32'd4);
    end_program = 1'b0;
    applyStimulus(2);
    checkOutput("done_hold", {31'b0, seq_done}, 32'd1);
    run_program = 1'b0;
    applyStimulus(1);
    checkOutput("done_exit", {31'b0, seq_done}, 32'd0);
    checkOutput("done_exit_busy", {31'b0, seq_busy}, 32'd0);

    // Asynchronous reset in the middle of ISSUE
    fetch_ready = 1'b0; send_consec_addr = 1'b0; consec_count = 8'd0;
    fifoPush(32'h6000);
    run_program = 1'b1;
    applyStimulus(3);
    checkOutput("arst_pre_valid", {31'b0, fetch_valid}, 32'd1);
    checkOutput("arst_pre_addr", fetch_addr, 32'h6000);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", {31'b0, fetch_valid}, 32'd0);
    checkOutput("arst_busy", {31'b0, seq_busy}, 32'd0);
    checkOutput("arst_done", {31'b0, seq_done}, 32'd0);
    checkOutput("arst_rd", {31'b0, addr_fifo_rd}, 32'd0);
    checkOutput("arst_addr", fetch_addr, 32'd0);
    checkOutput("arst_issued", fetch_issued, 32'd0);
    checkOutput("leftover_expected", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
